snake_move_module: RTL and testbench

Snake motion and collision engine for the snake game. It consumes the 3-bit `Game_status` and the direction keys from the game control block, and advances the snake one grid cell per move tick while in PLAY. It raises `Hit_wall_sig` / `Hit_body_sig` back to the game control block, which uses them to enter END. It also answers per-cell occupancy queries from the VGA draw logic.

---
 rtl/snake_move_module.sv | 260 ++++++++++++++++++++++++++
 tb/tb_snake_move_module.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_module.sv
// snake_move_module: snake motion, collision and cell-occupancy engine.
// Advances the snake one grid cell per move tick while the game is in PLAY,
// reports wall/body collisions as one-cycle pulses and answers registered
// per-cell occupancy queries for the draw logic.
// Optional feature: define SNAKE_WRAP_EN to make the grid edges wrap around
// (no wall collisions). Without it, leaving the grid is a wall hit.
module snake_move_module #(
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int X_W      = 6,
   parameter int Y_W      = 5,
   parameter int MAX_LEN  = 16,
   parameter int LEN_W    = 5,
   parameter int STEP_DIV = 12_500_000
) (
   input  logic             Clk_50mhz,
   input  logic             Rst,
   input  logic [2:0]       Game_status,
   input  logic             Key_left,
   input  logic             Key_right,
   input  logic             Key_up,
   input  logic             Key_down,
   input  logic             Grow,
   input  logic [X_W-1:0]   Query_x,
   input  logic [Y_W-1:0]   Query_y,
   output logic             Is_head,
   output logic             Is_body,
   output logic [X_W-1:0]   Head_x,
   output logic [Y_W-1:0]   Head_y,
   output logic [LEN_W-1:0] Snake_len,
   output logic             Move_tick,
   output logic             Hit_wall_sig,
   output logic             Hit_body_sig
);

   localparam logic [2:0] ST_START = 3'b001;
   localparam logic [2:0] ST_PLAY  = 3'b010;

   localparam int                CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);

   localparam logic [X_W-1:0]   INIT_X   = X_W'(20);
   localparam logic [Y_W-1:0]   INIT_Y   = Y_W'(15);
   localparam logic [LEN_W-1:0] INIT_LEN = LEN_W'(3);

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   function automatic dir_t f_reverse(input dir_t d);
      case (d)
         DIR_UP:   f_reverse = DIR_DOWN;
         DIR_DOWN: f_reverse = DIR_UP;
         DIR_LEFT: f_reverse = DIR_RIGHT;
         default:  f_reverse = DIR_LEFT;
      endcase
   endfunction

   // Segment storage; index 0 is the head.
   logic [X_W-1:0]   r_seg_x [MAX_LEN];
   logic [Y_W-1:0]   r_seg_y [MAX_LEN];
   logic [LEN_W-1:0] r_len;
   dir_t             r_dir;
   dir_t             r_ndir;
   logic             r_grow_pending;
   logic             r_dead;
   logic [CNT_W-1:0] r_cnt;
   logic             r_move_tick;
   logic             r_hit_wall;
   logic             r_hit_body;
   logic             r_is_head;
   logic             r_is_body;

   logic             w_init;
   logic             w_run;
   logic             w_tick;
   logic             w_key_any;
   logic             w_key_ok;
   dir_t             w_key_dir;
   logic [X_W-1:0]   w_next_x;
   logic [Y_W-1:0]   w_next_y;
   logic             w_wall;
   logic             w_body;
   logic             w_move;
   logic             w_q_head;
   logic             w_q_body;

   // Init has priority over everything, including a tick on the same edge.
   assign w_init = Rst || (Game_status == ST_START);
   assign w_run  = (Game_status == ST_PLAY) && !r_dead;
   assign w_tick = w_run && (r_cnt == CNT_LAST);
   assign w_move = w_tick && !w_wall && !w_body;

   // Key decode: priority up > down > left > right, then reject reversals.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_key_any = Key_up | Key_down | Key_left | Key_right;
      w_key_dir = DIR_RIGHT;
      if (Key_up)        w_key_dir = DIR_UP;
      else if (Key_down) w_key_dir = DIR_DOWN;
      else if (Key_left) w_key_dir = DIR_LEFT;
      w_key_ok = w_key_any && (w_key_dir != f_reverse(r_dir));
   end

   // Next head position and wall detection (or wrap) in the pending direction.
   always_comb begin
      w_next_x = r_seg_x[0];
      w_next_y = r_seg_y[0];
      w_wall   = 1'b0;
      case (r_ndir)
         DIR_UP: begin
            if (r_seg_y[0] == '0) begin
`ifdef SNAKE_WRAP_EN
               w_next_y = Y_W'(GRID_H - 1);
`else
               w_wall   = 1'b1;
`endif
            end else begin
               w_next_y = r_seg_y[0] - Y_W'(1);
            end
         end
         DIR_DOWN: begin
            if (r_seg_y[0] == Y_W'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
               w_next_y = '0;
`else
               w_wall   = 1'b1;
`endif
            end else begin
               w_next_y = r_seg_y[0] + Y_W'(1);
            end
         end
         DIR_LEFT: begin
            if (r_seg_x[0] == '0) begin
`ifdef SNAKE_WRAP_EN
               w_next_x = X_W'(GRID_W - 1);
`else
               w_wall   = 1'b1;
`endif
            end else begin
               w_next_x = r_seg_x[0] - X_W'(1);
            end
         end
         default: begin
            if (r_seg_x[0] == X_W'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
               w_next_x = '0;
`else
               w_wall   = 1'b1;
`endif
            end else begin
               w_next_x = r_seg_x[0] + X_W'(1);
            end
         end
      endcase
   end

   // Body hit: the tail cell is free to enter unless it stays put due to growth.
   always_comb begin
      w_body = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < r_len) &&
             (r_grow_pending || (LEN_W'(i) != r_len - LEN_W'(1))) &&
             (r_seg_x[i] == w_next_x) && (r_seg_y[i] == w_next_y))
            w_body = 1'b1;
      end
   end

   // Occupancy of the queried cell; segments beyond the length never match.
   always_comb begin
      w_q_head = (r_seg_x[0] == Query_x) && (r_seg_y[0] == Query_y);
      w_q_body = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < r_len) && (r_seg_x[i] == Query_x) && (r_seg_y[i] == Query_y))
            w_q_body = 1'b1;
      end
   end

   // Control state: step counter, direction, growth, death, length and pulses.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk_50mhz) begin
      if (w_init) begin
         r_cnt          <= '0;
         r_dir          <= DIR_RIGHT;
         r_ndir         <= DIR_RIGHT;
         r_grow_pending <= 1'b0;
         r_dead         <= 1'b0;
         r_len          <= INIT_LEN;
         r_move_tick    <= 1'b0;
         r_hit_wall     <= 1'b0;
         r_hit_body     <= 1'b0;
      end else begin
         r_move_tick <= w_move;
         r_hit_wall  <= w_tick && w_wall;
         r_hit_body  <= w_tick && !w_wall && w_body;
         if (w_run)
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
         if (w_tick)
            r_dir <= r_ndir;
         if (w_key_ok)
            r_ndir <= w_key_dir;
         if (w_move)
            r_grow_pending <= 1'b0;
         else if (Grow)
            r_grow_pending <= 1'b1;
         if (w_tick && (w_wall || w_body))
            r_dead <= 1'b1;
         if (w_move && r_grow_pending && (r_len < LEN_W'(MAX_LEN)))
            r_len <= r_len + LEN_W'(1);
      end
   end

   // Segment shift on each move; init places the three starting segments.
   // NOTE: only the live segments are initialised; cells past the length are never observed.
   always_ff @(posedge Clk_50mhz) begin
      if (w_init) begin
         r_seg_x[0] <= INIT_X;
         r_seg_y[0] <= INIT_Y;
         r_seg_x[1] <= INIT_X - X_W'(1);
         r_seg_y[1] <= INIT_Y;
         r_seg_x[2] <= INIT_X - X_W'(2);
         r_seg_y[2] <= INIT_Y;
      end else if (w_move) begin
         for (int i = MAX_LEN - 1; i > 0; i--) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
         end
         r_seg_x[0] <= w_next_x;
         r_seg_y[0] <= w_next_y;
      end
   end

   // Registered query answers.
   always_ff @(posedge Clk_50mhz) begin
      if (Rst) begin
         r_is_head <= 1'b0;
         r_is_body <= 1'b0;
      end else begin
         r_is_head <= w_q_head;
         r_is_body <= w_q_body;
      end
   end

   assign Head_x       = r_seg_x[0];
   assign Head_y       = r_seg_y[0];
   assign Snake_len    = r_len;
   assign Move_tick    = r_move_tick;
`ifdef SNAKE_WRAP_EN
   assign Hit_wall_sig = 1'b0;
`else
   assign Hit_wall_sig = r_hit_wall;
`endif
   assign Hit_body_sig = r_hit_body;
   assign Is_head      = r_is_head;
   assign Is_body      = r_is_body;

endmodule

// File: tb/tb_snake_move_module.sv
// Directed testbench for snake_move_module with a short move interval.
module tb_snake_move_module;

   localparam int STEP_DIV = 4;
   localparam logic [2:0] ST_START = 3'b001;
   localparam logic [2:0] ST_PLAY  = 3'b010;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] status;
   logic       k_left, k_right, k_up, k_down, grow;
   logic [5:0] q_x;
   logic [4:0] q_y;
   logic       is_head, is_body;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic [4:0] snake_len;
   logic       move_tick, hit_wall, hit_body;

   int n_checks = 0;
   int n_fail   = 0;
   int gap;
   bit seen;
   int moves;

   always #5 clk = ~clk;

   snake_move_module #(.STEP_DIV(STEP_DIV)) dut (
      .Clk_50mhz    (clk),
      .Rst          (rst),
      .Game_status  (status),
      .Key_left     (k_left),
      .Key_right    (k_right),
      .Key_up       (k_up),
      .Key_down     (k_down),
      .Grow         (grow),
      .Query_x      (q_x),
      .Query_y      (q_y),
      .Is_head      (is_head),
      .Is_body      (is_body),
      .Head_x       (head_x),
      .Head_y       (head_y),
      .Snake_len    (snake_len),
      .Move_tick    (move_tick),
      .Hit_wall_sig (hit_wall),
      .Hit_body_sig (hit_body)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Advance negedge by negedge until any pulse is seen or the budget runs out.
   task automatic wait_pulse(input int limit, output int n, output bit got);
      n   = 0;
      got = 1'b0;
      while (!got && (n < limit)) begin
         @(negedge clk);
         n++;
         if (move_tick || hit_wall || hit_body)
            got = 1'b1;
      end
   endtask

   // Hold the given keys / grow for one clock, then release.
   task automatic press(input logic u, input logic d, input logic l, input logic r, input logic g);
      k_up = u; k_down = d; k_left = l; k_right = r; grow = g;
      @(negedge clk);
      k_up = 1'b0; k_down = 1'b0; k_left = 1'b0; k_right = 1'b0; grow = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; status = ST_START;
      k_left = 1'b0; k_right = 1'b0; k_up = 1'b0; k_down = 1'b0; grow = 1'b0;
      q_x = '0; q_y = '0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_head_x", head_x, 20);
      check("rst_head_y", head_y, 15);
      check("rst_len", snake_len, 3);
      check("rst_move_tick", move_tick, 0);
      check("rst_hit_wall", hit_wall, 0);
      check("rst_hit_body", hit_body, 0);
      check("rst_is_head", is_head, 0);
      check("rst_is_body", is_body, 0);

      // Occupancy queries on the initial snake
      rst = 1'b0;
      q_x = 6'd19; q_y = 5'd15; @(negedge clk);
      check("q19_body", is_body, 1);
      check("q19_head", is_head, 0);
      q_x = 6'd20; @(negedge clk);
      check("q20_head", is_head, 1);
      check("q20_body", is_body, 0);
      q_x = 6'd17; @(negedge clk);
      check("q17_head", is_head, 0);
      check("q17_body", is_body, 0);

      // Free running to the right: a move every STEP_DIV cycles
      status = ST_PLAY;
      for (int m = 1; m <= 3; m++) begin
         wait_pulse(20, gap, seen);
         check("run_gap", gap, STEP_DIV);
         check("run_move_tick", move_tick, 1);
         check("run_head_x", head_x, 20 + m);
         check("run_head_y", head_y, 15);
         check("run_len", snake_len, 3);
      end

      // Reverse key ignored, then up wins over left
      press(0, 0, 1, 0, 0);
      wait_pulse(20, gap, seen);
      check("rev_head_x", head_x, 24);
      check("rev_head_y", head_y, 15);
      press(1, 0, 1, 0, 0);
      wait_pulse(20, gap, seen);
      check("up_head_x", head_x, 24);
      check("up_head_y", head_y, 14);

      // Growth: turn right and grow; the old tail stays in place
      press(0, 0, 0, 1, 1);
      wait_pulse(20, gap, seen);
      check("grow_head_x", head_x, 25);
      check("grow_len", snake_len, 4);
      q_x = 6'd23; q_y = 5'd15; @(negedge clk);
      check("grow_tail_body", is_body, 1);
      for (int k = 1; k <= 13; k++) begin
         press(0, 0, 0, 0, 1);
         wait_pulse(20, gap, seen);
         check("grow_sat_len", snake_len, (4 + k > 16) ? 16 : 4 + k);
      end
      check("grow_final_x", head_x, 38);

      // Re-init, then run into the right wall
      status = ST_START; @(negedge clk);
      check("init_head_x", head_x, 20);
      check("init_len", snake_len, 3);
      status = ST_PLAY;
      moves = 0;
      for (int m = 0; m < 19; m++) begin
         wait_pulse(20, gap, seen);
         if (seen && move_tick) moves++;
      end
      check("wall_moves", moves, 19);
      check("wall_edge_x", head_x, 39);
      wait_pulse(20, gap, seen);
`ifdef SNAKE_WRAP_EN
      check("wrap_move_tick", move_tick, 1);
      check("wrap_hit_wall", hit_wall, 0);
      check("wrap_head_x", head_x, 0);
`else
      check("wall_gap", gap, STEP_DIV);
      check("wall_hit", hit_wall, 1);
      check("wall_move_tick", move_tick, 0);
      check("wall_hold_x", head_x, 39);
      wait_pulse(12, gap, seen);
      check("wall_frozen", seen, 0);
      check("wall_frozen_x", head_x, 39);
`endif

      // Body collision: length 5, then up / left / down
      status = ST_START; @(negedge clk);
      status = ST_PLAY;
      press(0, 0, 0, 0, 1);
      wait_pulse(20, gap, seen);
      press(0, 0, 0, 0, 1);
      wait_pulse(20, gap, seen);
      check("body_len", snake_len, 5);
      check("body_pre_x", head_x, 22);
      press(1, 0, 0, 0, 0);
      wait_pulse(20, gap, seen);
      press(0, 0, 1, 0, 0);
      wait_pulse(20, gap, seen);
      check("body_turn_x", head_x, 21);
      check("body_turn_y", head_y, 14);
      press(0, 1, 0, 0, 0);
      wait_pulse(20, gap, seen);
      check("body_hit", hit_body, 1);
      check("body_move_tick", move_tick, 0);
      check("body_hold_x", head_x, 21);
      check("body_hold_y", head_y, 14);
      wait_pulse(12, gap, seen);
      check("body_frozen", seen, 0);
      status = ST_START; @(negedge clk);
      check("restart_head_x", head_x, 20);
      check("restart_head_y", head_y, 15);
      check("restart_len", snake_len, 3);
      check("restart_hit_body", hit_body, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
